// File: rtl/uart_pkg.sv
// UART shared constants.
// State encoding and oversampling points used by both RX and TX.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/uart_rx_if.sv
// UART receiver bundle: baud tick and line in, word and status out.
// master drives the line/tick side, slave is the receiver.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            I_BAUD_TICK;
  logic            I_RX;
  logic [DBIT-1:0] O_DATA;
  logic            O_RX_DONE;
  logic            O_FRAME_ERR;
  logic            O_BUSY;

  modport master (
    output I_BAUD_TICK,
    output I_RX,
    input  O_DATA,
    input  O_RX_DONE,
    input  O_FRAME_ERR,
    input  O_BUSY
  );

  modport slave (
    input  I_BAUD_TICK,
    input  I_RX,
    output O_DATA,
    output O_RX_DONE,
    output O_FRAME_ERR,
    output O_BUSY
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL sets the value both flops take during reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic I_CLK,
  input  logic I_RST,
  input  logic I_D,
  output logic O_Q
);

  logic r_ff1;
  logic r_ff2;

  // Shift the async input through two flops.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_ff1 <= RST_VAL;
      r_ff2 <= RST_VAL;
    end else begin
      r_ff1 <= I_D;
      r_ff2 <= r_ff1;
    end
  end

  assign O_Q = r_ff2;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, 1 start, DBIT data, no parity.
// Start bit is qualified at mid-bit, data bits sampled at their centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic     I_CLK,
  input  logic     I_RST,
  uart_rx_if.slave bus
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;
  localparam int BW = $clog2(DBIT);

  logic            w_rx_s;
  state_t          r_state;
  state_t          w_state;
  logic [SW-1:0]   r_s;
  logic [SW-1:0]   w_s;
  logic [BW-1:0]   r_b;
  logic [BW-1:0]   w_b;
  logic [DBIT-1:0] r_d;
  logic [DBIT-1:0] w_d;
  logic [DBIT-1:0] r_data;
  logic [DBIT-1:0] w_data;
  logic            r_done;
  logic            w_done;
  logic            r_ferr;
  logic            w_ferr;
  logic            r_busy;

  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .I_CLK(I_CLK),
    .I_RST(I_RST),
    .I_D  (bus.I_RX),
    .O_Q  (w_rx_s)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_s     <= w_s;
      r_b     <= w_b;
      r_d     <= w_d;
      r_data  <= w_data;
      r_done  <= w_done;
      r_ferr  <= w_ferr;
      r_busy  <= (w_state != IDLE);
    end
  end

  // Next-state and datapath updates; ticks gate all but IDLE.
  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_b     = r_b;
    w_d     = r_d;
    w_data  = r_data;
    w_ferr  = r_ferr;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state = START;
          w_s     = '0;
        end
      end
      START: begin
        if (bus.I_BAUD_TICK) begin
          if (r_s == SW'(MID_SAMPLE)) begin
            w_s = '0;
            if (!w_rx_s) begin
              w_state = DATA;
              w_b     = '0;
            end else begin
              w_state = IDLE;
            end
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      DATA: begin
        if (bus.I_BAUD_TICK) begin
          if (r_s == SW'(OVERSAMPLE - 1)) begin
            w_s = '0;
            w_d = {w_rx_s, r_d[DBIT-1:1]};
            if (r_b == BW'(DBIT - 1)) begin
              w_state = STOP;
            end else begin
              w_b = r_b + BW'(1);
            end
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      STOP: begin
        if (bus.I_BAUD_TICK) begin
          if (r_s == SW'(SB_TICK - 1)) begin
            w_state = IDLE;
            w_s     = '0;
            w_data  = r_d;
            w_ferr  = ~w_rx_s;
            w_done  = 1'b1;
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign bus.O_DATA      = r_data;
  assign bus.O_RX_DONE   = r_done;
  assign bus.O_FRAME_ERR = r_ferr;
  assign bus.O_BUSY      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: behavioural serial sender plus expected-frame queues.
// Two instances: 8N1 and 7-bit with a 2-stop-bit window.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int TDIV = 4;

  typedef struct {
    logic [7:0] d;
    logic       e;
    time        t0;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cnt = 2'd0;
  logic       tick;
  logic       pd_a = 1'b0;
  logic       pd_b = 1'b0;
  int         n_run = 0;
  int         n_fail = 0;
  exp_t       q_a[$];
  exp_t       q_b[$];

  uart_rx_if #(.DBIT(8)) ifa();
  uart_rx_if #(.DBIT(7)) ifb();

  assign ifa.I_BAUD_TICK = tick;
  assign ifb.I_BAUD_TICK = tick;

  uart_rx #(
    .DBIT   (8),
    .SB_TICK(16)
  ) u_dut_a (
    .I_CLK(clk),
    .I_RST(rst),
    .bus  (ifa)
  );

  uart_rx #(
    .DBIT   (7),
    .SB_TICK(32)
  ) u_dut_b (
    .I_CLK(clk),
    .I_RST(rst),
    .bus  (ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 2'd1;
  assign tick = (cnt == 2'd3);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tkw(input int n);
    repeat (n) @(posedge clk iff tick);
    #1;
  endtask

  task automatic setrx(input int w, input logic v);
    if (w == 0) ifa.I_RX = v;
    else ifb.I_RX = v;
  endtask

  // One frame, aligned to tick edges; expectation queued first.
  task automatic send(input int w, input logic [7:0] v,
                      input int nb, input int sb,
                      input bit good, input int gap,
                      input bit exp_it);
    exp_t       e;
    logic [7:0] m;
    m     = v & 8'((1 << nb) - 1);
    e.d   = m;
    e.e   = ~good;
    e.t0  = $time - 1 + TDIV * 10;
    e.lat = TDIV * (7 + 16 * nb + sb) + 1;
    if (exp_it) begin
      if (w == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
    setrx(w, 1'b0);
    tkw(16);
    for (int i = 0; i < nb; i++) begin
      setrx(w, m[i]);
      tkw(16);
    end
    if (good) begin
      setrx(w, 1'b1);
      tkw(sb);
    end else begin
      setrx(w, 1'b0);
      tkw(sb - 8);
      setrx(w, 1'b1);
      tkw(8);
    end
    if (gap > 0) tkw(gap);
  endtask

  task automatic mon(input int w, input logic dn,
                     input logic [7:0] d, input logic fe);
    exp_t  e;
    logic  pd;
    bit    empty;
    string tg;
    tg    = (w == 0) ? "a" : "b";
    pd    = (w == 0) ? pd_a : pd_b;
    empty = (w == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
    if (dn) begin
      chk({"pulse_", tg}, 32'(pd), 32'd0);
      if (empty) begin
        chk({"unexp_done_", tg}, 32'(dn), 32'd0);
      end else begin
        if (w == 0) e = q_a.pop_front();
        else e = q_b.pop_front();
        chk({"data_", tg}, 32'(d), 32'(e.d));
        chk({"ferr_", tg}, 32'(fe), 32'(e.e));
        chk({"lat_", tg},
            32'(($time - e.t0 + 5) / 10), 32'(e.lat));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ifa.O_RX_DONE, ifa.O_DATA, ifa.O_FRAME_ERR);
      mon(1, ifb.O_RX_DONE, {1'b0, ifb.O_DATA}, ifb.O_FRAME_ERR);
      pd_a <= ifa.O_RX_DONE;
      pd_b <= ifb.O_RX_DONE;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    bit         good;
    int         gap;

    ifa.I_RX = 1'b1;
    ifb.I_RX = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_a", 32'(ifa.O_DATA), 32'd0);
    chk("rst_done_a", 32'(ifa.O_RX_DONE), 32'd0);
    chk("rst_ferr_a", 32'(ifa.O_FRAME_ERR), 32'd0);
    chk("rst_busy_a", 32'(ifa.O_BUSY), 32'd0);
    chk("rst_data_b", 32'(ifb.O_DATA), 32'd0);
    chk("rst_busy_b", 32'(ifb.O_BUSY), 32'd0);
    rst = 1'b0;
    tkw(1);

    fork
      send(0, 8'hA5, 8, 16, 1'b1, 16, 1'b1);
      begin
        tkw(40);
        chk("busy_mid", 32'(ifa.O_BUSY), 32'd1);
      end
    join
    chk("busy_idle", 32'(ifa.O_BUSY), 32'd0);

    send(0, 8'h00, 8, 16, 1'b1, 0, 1'b1);
    send(0, 8'hFF, 8, 16, 1'b1, 16, 1'b1);

    setrx(0, 1'b0);
    tkw(5);
    setrx(0, 1'b1);
    tkw(16);
    chk("glitch_busy", 32'(ifa.O_BUSY), 32'd0);
    chk("glitch_data", 32'(ifa.O_DATA), 32'hFF);

    send(0, 8'h3C, 8, 16, 1'b0, 16, 1'b1);
    send(0, 8'h55, 8, 16, 1'b1, 16, 1'b1);
    chk("ferr_clear", 32'(ifa.O_FRAME_ERR), 32'd0);

    fork
      send(0, 8'h81, 8, 16, 1'b1, 16, 1'b0);
      begin
        tkw(88);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", 32'(ifa.O_DATA), 32'd0);
        chk("mid_rst_done", 32'(ifa.O_RX_DONE), 32'd0);
        chk("mid_rst_ferr", 32'(ifa.O_FRAME_ERR), 32'd0);
        chk("mid_rst_busy", 32'(ifa.O_BUSY), 32'd0);
      end
    join
    rst = 1'b0;
    send(0, 8'h81, 8, 16, 1'b1, 16, 1'b1);

    for (int k = 0; k < 12; k++) begin
      v    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      gap  = good ? 16 * int'($urandom_range(0, 1)) : 16;
      send(0, v, 8, 16, good, gap, 1'b1);
    end

    send(1, 8'h5A, 7, 32, 1'b1, 16, 1'b1);
    for (int k = 0; k < 4; k++) begin
      v    = 8'($urandom);
      good = ($urandom_range(0, 2) != 0);
      gap  = good ? 16 * int'($urandom_range(0, 1)) : 16;
      send(1, v, 7, 32, good, gap, 1'b1);
    end

    tkw(40);
    chk("pend_a", 32'(q_a.size()), 32'd0);
    chk("pend_b", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
